// File: rtl/bss_4_if.sv
// bss_4_if: start/operand request and busy/done/result response bundle for the bit-serial subtractor
interface bss_4_if;
  logic       start;
  logic [3:0] A_in;
  logic [3:0] B_in;
  logic       B_1;
  logic       busy;
  logic       done;
  logic [3:0] S;
  logic       BO;
  logic       OV;
  modport master (output start, A_in, B_in, B_1, input busy, done, S, BO, OV);
  modport slave  (input start, A_in, B_in, B_1, output busy, done, S, BO, OV);
endinterface

// File: rtl/bss_4.sv
// bss_4: 4-bit bit-serial subtractor, one full-subtractor cell plus a borrow flop, LSB first
module bss_4 (
  input logic   sys_clk,
  input logic   sys_rst_n,
  bss_4_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t     state;
  logic [1:0] cnt;
  logic [3:0] a_r, b_r;
  logic [2:0] s_sh;
  logic       bor;
  logic       a_b, b_b, d, bout;
  assign a_b  = a_r[cnt];
  assign b_b  = b_r[cnt];
  assign d    = a_b ^ b_b ^ bor;
  assign bout = (~a_b & b_b) | (~(a_b ^ b_b) & bor);
  // partial difference bits live in s_sh so S only changes on completion
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      a_r      <= 4'h0;
      b_r      <= 4'h0;
      s_sh     <= 3'h0;
      bor      <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.S    <= 4'h0;
      bus.BO   <= 1'b0;
      bus.OV   <= 1'b0;
    end else if (state == CALC) begin
      s_sh <= {d, s_sh[2:1]};
      bor  <= bout;
      cnt  <= cnt + 2'd1;
      if (cnt == 2'd3) begin
        bus.S    <= {d, s_sh};
        bus.BO   <= bout;
        bus.OV   <= (a_r[3] ^ b_r[3]) & (d ^ a_r[3]);
        state    <= DONE;
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
      end
    end else if (bus.start) begin
      a_r      <= bus.A_in;
      b_r      <= bus.B_in;
      bor      <= bus.B_1;
      cnt      <= 2'd0;
      state    <= CALC;
      bus.busy <= 1'b1;
      bus.done <= 1'b0;
    end else begin
      state    <= IDLE;
      bus.done <= 1'b0;
    end
  end
endmodule

// File: tb/tb_bss_4.sv
// tb_bss_4: directed checks of the bit-serial subtractor against hand-computed results
module tb_bss_4;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bss_4_if bus();
  bss_4 dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;

  // drives one start pulse, returns at the negedge where done is seen
  task automatic op(input logic [3:0] a, input logic [3:0] b, input logic bi,
                    output int bc, output bit ok);
    @(negedge sys_clk);
    bus.start = 1'b1; bus.A_in = a; bus.B_in = b; bus.B_1 = bi;
    @(negedge sys_clk);
    bus.start = 1'b0;
    bc = 0; ok = 1'b0;
    for (int i = 0; i < 12 && !ok; i++) begin
      if (bus.done) ok = 1'b1;
      else begin
        if (bus.busy) bc++;
        @(negedge sys_clk);
      end
    end
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.S, bus.BO, bus.OV} !== 8'h00) begin
      failures++;
      $display("FAIL reset_state got=%h want=00", {bus.busy, bus.done, bus.S, bus.BO, bus.OV});
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int bc; bit ok;
    op(4'd5, 4'd3, 1'b0, bc, ok);
    checks++;
    if (!ok || bc != 4) begin
      failures++;
      $display("FAIL basic_latency done=%0d busy_cycles=%0d want done=1 busy_cycles=4", ok, bc);
    end
    checks++;
    if ({bus.S, bus.BO, bus.OV} !== {4'h2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_result S=%h BO=%b OV=%b want S=2 BO=0 OV=0", bus.S, bus.BO, bus.OV);
    end
    @(negedge sys_clk);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.S !== 4'h2) begin
      failures++;
      $display("FAIL basic_one_cycle done=%b busy=%b S=%h want done=0 busy=0 S=2", bus.done, bus.busy, bus.S);
    end
  endtask

  task automatic test_vectors;
    logic [3:0] av [6] = '{4'd2, 4'd0, 4'd8, 4'd7, 4'd15, 4'd0};
    logic [3:0] bv [6] = '{4'd3, 4'd0, 4'd1, 4'd8, 4'd0, 4'd15};
    logic       iv [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [5:0] ev [6] = '{{4'hE, 2'b10}, {4'hF, 2'b10}, {4'h7, 2'b01},
                           {4'hE, 2'b11}, {4'hF, 2'b00}, {4'h0, 2'b10}};
    int bc; bit ok;
    for (int i = 0; i < 6; i++) begin
      op(av[i], bv[i], iv[i], bc, ok);
      checks++;
      if (!ok || {bus.S, bus.BO, bus.OV} !== ev[i]) begin
        failures++;
        $display("FAIL vector_%0d done=%0d S/BO/OV=%h want %h", i, ok, {bus.S, bus.BO, bus.OV}, ev[i]);
      end
    end
  endtask

  task automatic test_hold;
    bit bad = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.A_in = 4'd9; bus.B_in = 4'd2; bus.B_1 = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (bus.S !== 4'h0 || bus.busy !== 1'b1) bad = 1'b1;
      @(negedge sys_clk);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL hold_during_calc S changed or busy dropped; want S=0 busy=1 for 4 cycles");
    end
    checks++;
    if (bus.done !== 1'b1 || bus.S !== 4'h7) begin
      failures++;
      $display("FAIL hold_result done=%b S=%h want done=1 S=7", bus.done, bus.S);
    end
  endtask

  task automatic test_ignore_start;
    int dones = 0;
    bit late_busy = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.A_in = 4'd5; bus.B_in = 4'd3; bus.B_1 = 1'b0;
    @(negedge sys_clk);
    bus.A_in = 4'd9; bus.B_in = 4'd9; bus.B_1 = 1'b1;
    @(negedge sys_clk);
    bus.start = 1'b0;
    for (int k = 1; k < 12; k++) begin
      if (bus.done) begin
        dones++;
        checks++;
        if (bus.S !== 4'h2) begin
          failures++;
          $display("FAIL ignore_start_result S=%h want 2", bus.S);
        end
      end
      if (k > 4 && bus.busy) late_busy = 1'b1;
      @(negedge sys_clk);
    end
    checks++;
    if (dones != 1 || late_busy) begin
      failures++;
      $display("FAIL ignore_start_count dones=%0d late_busy=%b want dones=1 late_busy=0", dones, late_busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] busy_w = 10'b0111101111;
    logic [9:0] done_w = 10'b1000010000;
    logic [9:0] busy_g, done_g;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.A_in = 4'd5; bus.B_in = 4'd3; bus.B_1 = 1'b0;
    @(negedge sys_clk);
    bus.A_in = 4'd4; bus.B_in = 4'd1;
    for (int k = 0; k < 10; k++) begin
      busy_g[k] = bus.busy;
      done_g[k] = bus.done;
      if (k == 4) begin
        checks++;
        if (bus.S !== 4'h2) begin
          failures++;
          $display("FAIL b2b_first S=%h want 2", bus.S);
        end
      end
      if (k == 9) begin
        bus.start = 1'b0;
        checks++;
        if (bus.S !== 4'h3) begin
          failures++;
          $display("FAIL b2b_second S=%h want 3", bus.S);
        end
      end
      @(negedge sys_clk);
    end
    checks++;
    if (busy_g !== busy_w || done_g !== done_w) begin
      failures++;
      $display("FAIL b2b_timing busy=%b done=%b want busy=%b done=%b", busy_g, done_g, busy_w, done_w);
    end
  endtask

  task automatic test_reset_abort;
    int bc; bit ok;
    bit saw_done = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b1; bus.A_in = 4'd12; bus.B_in = 4'd3; bus.B_1 = 1'b0;
    @(negedge sys_clk);
    bus.start = 1'b0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.S, bus.BO, bus.OV} !== 8'h00) begin
      failures++;
      $display("FAIL abort_async got=%h want=00", {bus.busy, bus.done, bus.S, bus.BO, bus.OV});
    end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (bus.done || bus.busy) saw_done = 1'b1;
      @(negedge sys_clk);
    end
    checks++;
    if (saw_done) begin
      failures++;
      $display("FAIL abort_no_done activity seen after aborted op; want none");
    end
    op(4'd1, 4'd1, 1'b0, bc, ok);
    checks++;
    if (!ok || bc != 4 || {bus.S, bus.BO} !== 5'h00) begin
      failures++;
      $display("FAIL abort_restart done=%0d busy_cycles=%0d S=%h BO=%b want 1/4/0/0", ok, bc, bus.S, bus.BO);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.A_in = 4'h0; bus.B_in = 4'h0; bus.B_1 = 1'b0;
    test_reset;
    test_basic;
    test_vectors;
    test_hold;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
